// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared encodings for the dispatch controller and its opcode classifier
package dispatch_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DECODE, ST_ISSUE, ST_DONE, ST_FAULT} state_t;
  typedef enum logic [1:0] {UNIT_NONE, UNIT_EU, UNIT_BIU, UNIT_FCU} unit_t;
  localparam int unsigned CLS_ARITH_I = 0;
  localparam int unsigned CLS_MOV     = 1;
  localparam int unsigned CLS_LDST    = 2;
  localparam int unsigned CLS_BRANCH  = 3;
  localparam int unsigned CLS_ARITH_R = 4;
  localparam int unsigned CLS_COMP    = 5;
  localparam logic [1:0] SEL_EU_ARITH_I = 2'd0;
  localparam logic [1:0] SEL_EU_ARITH_R = 2'd1;
  localparam logic [1:0] SEL_EU_COMP    = 2'd2;
  localparam logic [1:0] SEL_BIU_MOV    = 2'd0;
  localparam logic [1:0] SEL_BIU_LDST   = 2'd1;
  localparam logic       SEL_FCU_BRANCH = 1'b0;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/dispatch_ctrl_opc_class.sv
// opc_class: counts leading ones of the opcode field and flags classes with no unit
module opc_class
  import dispatch_pkg::*;
#(
  parameter int OPC_W = 6,
  parameter int CLS_W = $clog2(OPC_W + 1)
) (
  input  logic [OPC_W-1:0] i_opc,
  output logic [CLS_W-1:0] o_cls,
  output logic             o_illegal
);
  logic w_run;
  // walk from the MSB, counting ones until the first zero
  always_comb begin
    o_cls = '0;
    w_run = 1'b1;
    for (int i = OPC_W - 1; i >= 0; i--) begin
      w_run = w_run & i_opc[i];
      o_cls = o_cls + CLS_W'(w_run);
    end
    o_illegal = 32'(o_cls) > CLS_COMP;
  end
endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: accepts one instruction, issues it to EU/BIU/FCU and reports done or fault
module dispatch_ctrl
  import dispatch_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int OPC_MSB = 21,
  parameter int OPC_W   = 6,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ir_valid,
  output logic            o_ir_ready,
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_eu_ready,
  input  logic            i_biu_ready,
  input  logic            i_fcu_ready,
  output logic            o_cs_eu,
  output logic            o_cs_biu,
  output logic            o_cs_fcu,
  output logic [1:0]      o_sel_eu,
  output logic [1:0]      o_sel_biu,
  output logic            o_sel_fcu,
  output logic            o_done,
  output logic            o_err,
  output logic [1:0]      o_err_code
);
  localparam int CLS_W = $clog2(OPC_W + 1);
  state_t            r_state, w_state_nxt;
  unit_t             r_unit, w_unit, w_unit_nxt;
  logic [IR_W-1:0]   r_ir;
  logic [CNT_W-1:0]  r_cnt;
  logic [CLS_W-1:0]  w_cls;
  logic [31:0]       w_c;
  logic              w_illegal, w_rdy, w_timeout, w_unused;
  logic [1:0]        w_sel_eu, w_sel_biu;
  logic              r_ir_ready, r_cs_eu, r_cs_biu, r_cs_fcu, r_sel_fcu, r_done, r_err;
  logic [1:0]        r_sel_eu, r_sel_biu, r_err_code;

  opc_class #(.OPC_W(OPC_W), .CLS_W(CLS_W)) u_opc_class (
    .i_opc     (r_ir[OPC_MSB -: OPC_W]),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_unused = ^r_ir;

  // map the captured class to a unit and sub-op, and pick the live ready/timeout
  always_comb begin
    w_c        = 32'(w_cls);
    w_unit     = (w_c == CLS_ARITH_I || w_c == CLS_ARITH_R || w_c == CLS_COMP) ? UNIT_EU :
                 (w_c == CLS_MOV || w_c == CLS_LDST) ? UNIT_BIU :
                 (w_c == CLS_BRANCH) ? UNIT_FCU : UNIT_NONE;
    w_sel_eu   = (w_c == CLS_COMP) ? SEL_EU_COMP : (w_c == CLS_ARITH_R) ? SEL_EU_ARITH_R : SEL_EU_ARITH_I;
    w_sel_biu  = (w_c == CLS_LDST) ? SEL_BIU_LDST : SEL_BIU_MOV;
    w_unit_nxt = (r_state == ST_DECODE) ? w_unit : r_unit;
    w_rdy      = (r_unit == UNIT_EU) ? i_eu_ready : (r_unit == UNIT_BIU) ? i_biu_ready :
                 (r_unit == UNIT_FCU) & i_fcu_ready;
    w_timeout  = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  end

  // next state; ready takes priority over a coinciding timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   w_state_nxt = i_ir_valid ? ST_DECODE : ST_IDLE;
      ST_DECODE: w_state_nxt = w_illegal ? ST_FAULT : ST_ISSUE;
      ST_ISSUE:  w_state_nxt = w_rdy ? ST_DONE : w_timeout ? ST_FAULT : ST_ISSUE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // capture, decode latches, watchdog and registered outputs driven from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir       <= '0;
      r_unit     <= UNIT_NONE;
      r_cnt      <= '0;
      r_sel_eu   <= SEL_EU_ARITH_I;
      r_sel_biu  <= SEL_BIU_MOV;
      r_sel_fcu  <= SEL_FCU_BRANCH;
      r_err_code <= ERR_NONE;
      r_ir_ready <= 1'b1;
      r_cs_eu    <= 1'b0;
      r_cs_biu   <= 1'b0;
      r_cs_fcu   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_ir_valid) r_ir <= i_ir;
      if (r_state == ST_DECODE && !w_illegal) begin
        r_unit    <= w_unit;
        r_sel_eu  <= w_sel_eu;
        r_sel_biu <= w_sel_biu;
        r_sel_fcu <= SEL_FCU_BRANCH;
      end
      if (r_state == ST_DECODE) r_cnt <= '0;
      else if (r_state == ST_ISSUE && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      if (w_state_nxt == ST_FAULT) r_err_code <= (r_state == ST_DECODE) ? ERR_ILLEGAL : ERR_TIMEOUT;
      r_ir_ready <= w_state_nxt == ST_IDLE;
      r_cs_eu    <= w_state_nxt == ST_ISSUE && w_unit_nxt == UNIT_EU;
      r_cs_biu   <= w_state_nxt == ST_ISSUE && w_unit_nxt == UNIT_BIU;
      r_cs_fcu   <= w_state_nxt == ST_ISSUE && w_unit_nxt == UNIT_FCU;
      r_done     <= w_state_nxt == ST_DONE;
      r_err      <= w_state_nxt == ST_FAULT;
    end
  end

  assign o_ir_ready = r_ir_ready;
  assign o_cs_eu    = r_cs_eu;
  assign o_cs_biu   = r_cs_biu;
  assign o_cs_fcu   = r_cs_fcu;
  assign o_sel_eu   = r_sel_eu;
  assign o_sel_biu  = r_sel_biu;
  assign o_sel_fcu  = r_sel_fcu;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed checks on a default-watchdog and a short-watchdog controller
module tb_dispatch_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, eu_r = 1'b0, biu_r = 1'b0, fcu_r = 1'b0;
  logic [31:0] ir = '0;
  logic a_rdy, a_ce, a_cb, a_cf, a_sf, a_done, a_err;
  logic [1:0] a_se, a_sb, a_ec;
  logic b_rdy, b_ce, b_cb, b_cf, b_sf, b_done, b_err;
  logic [1:0] b_se, b_sb, b_ec;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dispatch_ctrl dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir_valid(valid), .o_ir_ready(a_rdy), .i_ir(ir),
    .i_eu_ready(eu_r), .i_biu_ready(biu_r), .i_fcu_ready(fcu_r),
    .o_cs_eu(a_ce), .o_cs_biu(a_cb), .o_cs_fcu(a_cf), .o_sel_eu(a_se), .o_sel_biu(a_sb),
    .o_sel_fcu(a_sf), .o_done(a_done), .o_err(a_err), .o_err_code(a_ec)
  );

  dispatch_ctrl #(.TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ir_valid(valid), .o_ir_ready(b_rdy), .i_ir(ir),
    .i_eu_ready(eu_r), .i_biu_ready(biu_r), .i_fcu_ready(fcu_r),
    .o_cs_eu(b_ce), .o_cs_biu(b_cb), .o_cs_fcu(b_cf), .o_sel_eu(b_se), .o_sel_biu(b_sb),
    .o_sel_fcu(b_sf), .o_done(b_done), .o_err(b_err), .o_err_code(b_ec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = 1'b0; ir = '0; eu_r = 1'b0; biu_r = 1'b0; fcu_r = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_ir_ready", {31'd0, a_rdy}, 32'd1);
    chk("rst_cs", {29'd0, a_ce, a_cb, a_cf}, 32'd0);
    chk("rst_sel", {27'd0, a_se, a_sb, a_sf}, 32'd0);
    chk("rst_done_err", {30'd0, a_done, a_err}, 32'd0);
    chk("rst_err_code", {30'd0, a_ec}, 32'd0);

    // class 0 -> EU arith-imm, ready on first ISSUE cycle
    ir = 32'h0000_0000; valid = 1'b1; eu_r = 1'b1;
    tick();
    valid = 1'b0;
    chk("c0_decode_ready", {31'd0, a_rdy}, 32'd0);
    chk("c0_decode_cs", {31'd0, a_ce}, 32'd0);
    tick();
    chk("c0_issue_cs", {29'd0, a_ce, a_cb, a_cf}, 32'd4);
    chk("c0_issue_sel", {30'd0, a_se}, 32'd0);
    tick();
    chk("c0_done", {31'd0, a_done}, 32'd1);
    chk("c0_done_cs", {31'd0, a_ce}, 32'd0);
    tick();
    chk("c0_idle_ready", {31'd0, a_rdy}, 32'd1);
    chk("c0_done_pulse", {31'd0, a_done}, 32'd0);

    // class 2 -> BIU load/store, ready after 10 cycles, other readies toggle
    do_reset();
    ir = 32'h0030_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("c2_sel_biu", {30'd0, a_sb}, 32'd1);
    for (int i = 0; i <= 10; i++) begin
      chk("c2_cs_biu", {29'd0, a_ce, a_cb, a_cf}, 32'd2);
      chk("c2_no_done", {31'd0, a_done}, 32'd0);
      eu_r = ~eu_r; fcu_r = ~fcu_r;
      if (i == 10) biu_r = 1'b1;
      tick();
    end
    chk("c2_done", {31'd0, a_done}, 32'd1);
    chk("c2_cs_off", {29'd0, a_ce, a_cb, a_cf}, 32'd0);

    // illegal opcode
    do_reset();
    ir = 32'h003F_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("ill_decode_cs", {29'd0, a_ce, a_cb, a_cf}, 32'd0);
    tick();
    chk("ill_err", {31'd0, a_err}, 32'd1);
    chk("ill_code", {30'd0, a_ec}, 32'd1);
    chk("ill_cs", {29'd0, a_ce, a_cb, a_cf}, 32'd0);
    tick();
    chk("ill_err_pulse", {31'd0, a_err}, 32'd0);
    chk("ill_code_hold", {30'd0, a_ec}, 32'd1);
    chk("ill_idle", {31'd0, a_rdy}, 32'd1);

    // class 3 -> FCU, watchdog of 4 cycles expires
    do_reset();
    ir = 32'h0038_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("to_cs_fcu", {29'd0, b_ce, b_cb, b_cf}, 32'd1);
      tick();
    end
    chk("to_cs_off", {29'd0, b_ce, b_cb, b_cf}, 32'd0);
    chk("to_err", {31'd0, b_err}, 32'd1);
    chk("to_code", {30'd0, b_ec}, 32'd2);
    chk("to_no_done", {31'd0, b_done}, 32'd0);

    // class 5 -> EU compare, ready arrives on the timeout cycle
    do_reset();
    ir = 32'h003E_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("c5_sel_eu", {30'd0, b_se}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk("c5_cs_eu", {29'd0, b_ce, b_cb, b_cf}, 32'd4);
      if (i == 3) eu_r = 1'b1;
      tick();
    end
    chk("c5_done", {31'd0, b_done}, 32'd1);
    chk("c5_no_err", {31'd0, b_err}, 32'd0);

    // valid held during ISSUE does not recapture
    do_reset();
    ir = 32'h0000_0000; valid = 1'b1;
    tick();
    ir = 32'h003F_0000;
    tick();
    chk("hold_cs_eu", {31'd0, a_ce}, 32'd1);
    tick();
    tick();
    chk("hold_still_issue", {30'd0, a_ce, a_rdy}, 32'd2);
    eu_r = 1'b1;
    tick();
    valid = 1'b0; eu_r = 1'b0;
    chk("hold_done", {31'd0, a_done}, 32'd1);
    chk("hold_no_err", {31'd0, a_err}, 32'd0);
    tick();

    // async reset in the middle of ISSUE
    ir = 32'h0030_0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    chk("ar_cs_biu", {31'd0, a_cb}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cs_async", {29'd0, a_ce, a_cb, a_cf}, 32'd0);
    chk("ar_ready_async", {31'd0, a_rdy}, 32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_after", {28'd0, a_rdy, a_cb, a_done, a_err}, 32'd8);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
